muldiv_seq_ctrl: RTL and testbench

- Sequencer for the ALU result-select path.
- Decodes the 6-bit funct code into a result-source select for the downstream output mux.
- Owns the Hi/Lo register pair and runs MULTU as a 32-iteration shift-add multiply that writes Hi/Lo.
- Asserts a stall to the issue stage whenever MFHI/MFLO or a new MULTU arrives while a multiply is in flight.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_seq_ctrl_mul_iter.sv | 28 ++
 rtl/muldiv_seq_ctrl.sv | 108 ++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared funct codes, result-select encodings, sequencer states
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [5:0] AND   = 6'b100100;
    localparam logic [5:0] OR    = 6'b100101;
    localparam logic [5:0] ADD   = 6'b100000;
    localparam logic [5:0] SUB   = 6'b100010;
    localparam logic [5:0] SLT   = 6'b101010;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MULTU = 6'b011001;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_HI   = 2'd1;
    localparam logic [1:0] SEL_LO   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [1:0] decode_sel(input logic [5:0] f);
        case (f)
            AND, OR, ADD, SUB, SLT: decode_sel = SEL_ALU;
            MFHI:                   decode_sel = SEL_HI;
            MFLO:                   decode_sel = SEL_LO;
            default:                decode_sel = SEL_ZERO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_ctrl_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : One shift-add multiply step (conditional add, shift right 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_product,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic [2*WIDTH-1:0] o_product
);

    logic [WIDTH:0] w_upper;

    // The add carry lands in the top bit so the shifted product stays exact.
    always_comb begin
        w_upper = {1'b0, i_product[2*WIDTH-1:WIDTH]};
        if (i_product[0]) begin
            w_upper = {1'b0, i_product[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand};
        end
    end

    assign o_product = {w_upper, i_product[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_ctrl
//  Description : Result-select decode, Hi/Lo ownership, sequential MULTU
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] w_product_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_last;
    logic               w_hilo_op;

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul_iter (
        .i_product (r_product),
        .i_mcand   (r_mcand),
        .o_product (w_product_next)
    );

    // A MULTU is taken from IDLE or DONE; during MUL it is stalled instead.
    assign w_accept  = start && (funct == MULTU) && (r_state != MUL);
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));
    assign w_hilo_op = (funct == MFHI) || (funct == MFLO) || (funct == MULTU);

    assign sel    = decode_sel(funct);
    assign hi_out = r_hi;
    assign lo_out = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = MUL;
            end
            MUL: begin
                busy  = 1'b1;
                stall = start && w_hilo_op;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = w_accept ? MUL : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_product <= '0;
            r_mcand   <= '0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_accept) begin
            r_product <= {{WIDTH{1'b0}}, op_b};
            r_mcand   <= op_a;
            r_count   <= '0;
        end else if (r_state == MUL) begin
            r_product <= w_product_next;
            r_count   <= r_count + CNT_W'(1);
            if (w_last) begin
                r_hi <= w_product_next[2*WIDTH-1:WIDTH];
                r_lo <= w_product_next[WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq_ctrl
//  Description : Directed self-checking bench for muldiv_seq_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  sel;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        stall;

    int passed = 0;
    int total  = 0;

    muldiv_seq_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct  (funct),
        .op_a   (op_a),
        .op_b   (op_b),
        .sel    (sel),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issues a MULTU at the current negedge, then walks negedges until done.
    // From cycle inj_k for inj_len cycles a second instruction (7x9) is held.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int inj_k, input int inj_len, input logic [5:0] inj_f,
                           output int busy_cnt, output int done_k, output int stall_cnt);
        start = 1'b1; funct = MULTU; op_a = a; op_b = b;
        busy_cnt = 0; done_k = 0; stall_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k >= inj_k && k < inj_k + inj_len) begin
                start = 1'b1; funct = inj_f; op_a = 32'd7; op_b = 32'd9;
            end else begin
                start = 1'b0; funct = ADD;
            end
            #1;
            if (done) begin
                done_k = k;
                break;
            end
            if (busy)  busy_cnt++;
            if (stall) stall_cnt++;
        end
    endtask

    int bc, dk, sc;
    logic [5:0] sweep_f [10];
    logic [1:0] sweep_s [10];
    int done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; funct = ADD; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy",  busy,   1'b0);
        check("rst_done",  done,   1'b0);
        check("rst_stall", stall,  1'b0);
        check("rst_hi",    hi_out, 32'h0);
        check("rst_lo",    lo_out, 32'h0);

        // 3 x 5
        run_mul(32'd3, 32'd5, 100, 0, ADD, bc, dk, sc);
        check("t1_busy_cycles", bc, 32);
        check("t1_done_at",     dk, 33);
        check("t1_hi",          hi_out, 32'h0000_0000);
        check("t1_lo",          lo_out, 32'h0000_000F);
        @(negedge clk); #1;
        check("t1_done_pulse_width", done, 1'b0);
        check("t1_idle_busy",        busy, 1'b0);

        // all-ones squared exercises the carry into the top bit
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, 0, ADD, bc, dk, sc);
        check("t2_done_at", dk, 33);
        check("t2_hi", hi_out, 32'hFFFF_FFFE);
        check("t2_lo", lo_out, 32'h0000_0001);
        @(negedge clk);

        // MFHI from cycle 5 on: stalled until DONE, then sees new Hi
        run_mul(32'h0001_0000, 32'h0003_0000, 5, 100, MFHI, bc, dk, sc);
        check("t3_done_at",      dk, 33);
        check("t3_stall_cycles", sc, 28);
        check("t3_sel_mfhi",     sel, SEL_HI);
        check("t3_stall_done",   stall, 1'b0);
        check("t3_hi_visible",   hi_out, 32'h0000_0003);
        check("t3_lo",           lo_out, 32'h0000_0000);
        @(negedge clk);
        start = 1'b0;

        // MULTU 7x9 issued during MUL is stalled and dropped
        run_mul(32'd100, 32'd200, 3, 1, MULTU, bc, dk, sc);
        check("t4_stall_cycles", sc, 1);
        check("t4_done_at",      dk, 33);
        check("t4_first_lo",     lo_out, 32'd20000);
        check("t4_first_hi",     hi_out, 32'd0);
        // re-issue in the DONE cycle
        run_mul(32'd7, 32'd9, 100, 0, ADD, bc, dk, sc);
        check("t4_reissue_done_at", dk, 33);
        check("t4_reissue_lo",      lo_out, 32'd63);
        check("t4_reissue_hi",      hi_out, 32'd0);
        @(negedge clk);

        // reset during iteration 10
        start = 1'b1; funct = MULTU; op_a = 32'h1234; op_b = 32'h5678;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0; funct = ADD;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_busy", busy,   1'b0);
        check("t5_done", done,   1'b0);
        check("t5_hi",   hi_out, 32'h0);
        check("t5_lo",   lo_out, 32'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("t5_no_done_after_abort", done_seen, 0);

        // funct sweep while idle
        sweep_f[0] = AND;      sweep_s[0] = 2'd0;
        sweep_f[1] = OR;       sweep_s[1] = 2'd0;
        sweep_f[2] = ADD;      sweep_s[2] = 2'd0;
        sweep_f[3] = SUB;      sweep_s[3] = 2'd0;
        sweep_f[4] = SLT;      sweep_s[4] = 2'd0;
        sweep_f[5] = 6'b010000; sweep_s[5] = 2'd1;
        sweep_f[6] = 6'b010010; sweep_s[6] = 2'd2;
        sweep_f[7] = 6'b000000; sweep_s[7] = 2'd3;
        sweep_f[8] = 6'b011001; sweep_s[8] = 2'd3;
        sweep_f[9] = 6'b111111; sweep_s[9] = 2'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            funct = sweep_f[i];
            start = (sweep_f[i] != 6'b011001);
            #1;
            check($sformatf("sweep_sel_%b", sweep_f[i]),   sel,   sweep_s[i]);
            check($sformatf("sweep_stall_%b", sweep_f[i]), stall, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
